// File: rtl/alu_iter_exec.sv
// Iterative-shift ALU execute stage: valid/ready request in, valid/ready result out.
// Encodings mirror ALUop.vh. Optional macro ALU_ITER_EXEC_BYPASS_EN lets DONE accept a new request.
package alu_iter_exec_pkg;
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_SRL    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;
  localparam logic [3:0] ALU_XXX    = 4'd15;
endpackage

module alu_iter_exec
  import alu_iter_exec_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  // One extra bit so a step of 8 fits even when WIDTH is 8.
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_d;
  logic             illegal_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             fill_q, fill_d;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             is_shift;
  logic [CW-1:0]    shamt;
  logic [CW-1:0]    step;
  logic [WIDTH-1:0] shifted;

  assign out_valid = (state_q == DONE);
`ifdef ALU_ITER_EXEC_BYPASS_EN
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
  assign in_ready  = (state_q == IDLE);
`endif
  assign accept    = in_valid && in_ready;
  assign shamt     = {1'b0, B[SHW-1:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (ALUop)
      ALU_ADD:    alu_res = A + B;
      ALU_SUB:    alu_res = A - B;
      ALU_AND:    alu_res = A & B;
      ALU_OR:     alu_res = A | B;
      ALU_XOR:    alu_res = A ^ B;
      ALU_SLT:    alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLTU:   alu_res = {{(WIDTH-1){1'b0}}, A < B};
      ALU_COPY_B: alu_res = B;
      ALU_SLL, ALU_SRA, ALU_SRL: is_shift = 1'b1;
      ALU_XXX:    alu_ill = 1'b1;
      default:    alu_ill = 1'b1;
    endcase
  end

  // The final step may be shorter than SHIFT_STEP; SRA fill comes from the captured sign.
  always_comb begin
    step = (cnt_q < STEP) ? cnt_q : STEP;
    if (left_q) shifted = result << step;
    else        shifted = (result >> step) | (fill_q ? ~({WIDTH{1'b1}} >> step) : '0);
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result;
    illegal_d = illegal;
    cnt_d     = cnt_q;
    left_d    = left_q;
    fill_d    = fill_q;
    case (state_q)
      SHIFT: begin
        result_d = shifted;
        cnt_d    = cnt_q - step;
        if (cnt_q == step) state_d = DONE;
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    // An accept (IDLE, or DONE in bypass builds) overrides the retire path.
    if (accept) begin
      left_d    = (ALUop == ALU_SLL);
      fill_d    = (ALUop == ALU_SRA) && A[WIDTH-1];
      illegal_d = alu_ill;
      cnt_d     = '0;
      if (is_shift && (shamt != '0)) begin
        result_d = A;
        cnt_d    = shamt;
        state_d  = SHIFT;
      end else begin
        result_d = is_shift ? A : alu_res;
        state_d  = DONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      result  <= '0;
      illegal <= 1'b0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      result  <= result_d;
      illegal <= illegal_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      fill_q  <= fill_d;
    end
  end
endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec: scoreboard queue of expected results, latency and handshake checks.
module tb_alu_iter_exec;
  import alu_iter_exec_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_valid4, out_ready;
  logic [3:0]   ALUop;
  logic [W-1:0] A, B;
  logic         in_ready, out_valid, illegal;
  logic [W-1:0] result;
  logic         in_ready4, out_valid4, illegal4;
  logic [W-1:0] result4;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_iter_exec #(.WIDTH(W), .SHIFT_STEP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  alu_iter_exec #(.WIDTH(W), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .ALUop(ALUop), .A(A), .B(B), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .illegal(illegal4)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transfer on the main instance must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", W'(out_valid), '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("illegal", W'(illegal), W'(e.ill));
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ei, input bit push);
    ALUop = op; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_at_accept", W'(in_ready), W'(1));
    if (push) sb.push_back('{er, ei});
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUop = 4'($urandom);
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check(tag, W'(lat), W'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ei,
                        input int lat);
    issue(op, a, b, er, ei, 1'b1);
    wait_valid(tag, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int idx, last, out_cnt, gap_exp, lat4;
    reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALUop = ALU_ADD;
    repeat (2) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_result", result, '0);
    check("rst_illegal", W'(illegal), '0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("lat_add",  ALU_ADD,  32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    run_op("lat_sub",  ALU_SUB,  32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("lat_and",  ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
    run_op("lat_or",   ALU_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1);
    run_op("lat_xor",  ALU_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1);
    run_op("lat_slt",  ALU_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
    run_op("lat_sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    run_op("lat_copy", ALU_COPY_B, 32'h5555_0000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1);
    run_op("lat_sll0", ALU_SLL,  32'h0000_ABCD, 32'h20, 32'h0000_ABCD, 1'b0, 1);
    run_op("lat_srl4", ALU_SRL,  32'hF000_0000, 32'h104, 32'h0F00_0000, 1'b0, 5);
    run_op("lat_sll31", ALU_SLL, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32);
    run_op("lat_sra31", ALU_SRA, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 32);
    run_op("lat_xxx",  ALU_XXX,  32'h1234_5678, 32'h9, 32'h0, 1'b1, 1);
    run_op("lat_undef", 4'hB,    32'h1234_5678, 32'h9, 32'h0, 1'b1, 1);

    // SRA through the SHIFT_STEP=4 instance.
    ALUop = ALU_SRA; A = 32'h8000_0000; B = 32'h1F; in_valid4 = 1'b1;
    @(negedge clk);
    check("step4_in_ready", W'(in_ready4), W'(1));
    @(posedge clk); #1;
    in_valid4 = 1'b0; A = $urandom; B = $urandom;
    lat4 = 1;
    @(negedge clk);
    while (!out_valid4 && lat4 < 100) begin
      @(negedge clk);
      lat4++;
    end
    check("step4_latency", W'(lat4), W'(9));
    check("step4_result", result4, 32'hFFFF_FFFF);
    check("step4_illegal", W'(illegal4), '0);
    @(posedge clk); #1;

    // Backpressure on COPY_B.
    out_ready = 1'b0;
    issue(ALU_COPY_B, 32'hDEAD_BEEF, 32'h1234, 32'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_result", result, 32'h1234);
      check("bp_in_ready", W'(in_ready), '0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_out_valid", W'(out_valid), '0);
    check("bp_after_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;

    // Reset in the middle of a 20-bit shift discards it.
    issue(ALU_SLL, 32'h1, 32'd20, 32'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    check("mid_shift_out_valid", W'(out_valid), '0);
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", W'(out_valid), '0);
    check("async_rst_in_ready", W'(in_ready), W'(1));
    check("async_rst_result", result, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_out_valid", W'(out_valid), '0);
    @(posedge clk); #1;

    // Stream of four ADDs with the sink always ready.
`ifdef ALU_ITER_EXEC_BYPASS_EN
    gap_exp = 1;
`else
    gap_exp = 2;
`endif
    idx = 0; last = -1; out_cnt = 0;
    for (int c = 0; c < 30 && (idx < 4 || sb.size() > 0); c++) begin
      if (idx < 4) begin
        in_valid = 1'b1; ALUop = ALU_ADD;
        A = W'(idx) * 32'h1111_1111; B = W'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        if (last >= 0) check("stream_gap", W'(c - last), W'(gap_exp));
        last = c;
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{A + B, 1'b0});
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream_count", W'(out_cnt), W'(4));
    check("scoreboard_empty", W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
